// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline, the port arbiter and the
// single-ported unified memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic [DATA_WIDTH-1:0] if_data_o;
  logic                  if_ack_o;
  logic [1:0]            dm_row_i;
  logic [ADDR_WIDTH-1:0] dm_addr_i;
  logic [DATA_WIDTH-1:0] dm_wdata_i;
  logic [DATA_WIDTH-1:0] dm_rdata_o;
  logic                  dm_ack_o;
  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  stall_if_o;
  logic                  stall_mem_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_row_i, dm_addr_i, dm_wdata_i,
    input  mem_rdata_i,
    output if_data_o, if_ack_o,
    output dm_rdata_o, dm_ack_o,
    output mem_en_o, mem_we_o,
    output mem_addr_o, mem_wdata_o,
    output stall_if_o, stall_mem_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output dm_row_i, dm_addr_i, dm_wdata_i,
    output mem_rdata_i,
    input  if_data_o, if_ack_o,
    input  dm_rdata_o, dm_ack_o,
    input  mem_en_o, mem_we_o,
    input  mem_addr_o, mem_wdata_o,
    input  stall_if_o, stall_mem_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch and MEM stage,
// data first, with a starvation guard that eventually forces a fetch.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk_i,
  input logic rst_i,
  mem_port_arbiter_if.slave bus
);

  localparam int LW =
    (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [LW-1:0] lat_q, lat_d;
  logic [SW-1:0] starve_q, starve_d;

  logic                  own_dm_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  if_ack_q;
  logic                  dm_ack_q;
  logic [DATA_WIDTH-1:0] if_data_q;
  logic [DATA_WIDTH-1:0] dm_rdata_q;

  logic dm_pend;
  logic starved;
  logic grant_if;
  logic grant_dm;
  logic last;

  always_comb begin
    dm_pend  = (bus.dm_row_i == 2'b01) ||
               (bus.dm_row_i == 2'b10);
    starved  = (starve_q == SW'(STARVE_LIMIT));
    grant_if = 1'b0;
    grant_dm = 1'b0;
    last     = 1'b0;
    state_d  = state_q;
    lat_d    = lat_q;
    starve_d = starve_q;

    unique case (state_q)
      IDLE: begin
        grant_if = bus.if_req_i & (~dm_pend | starved);
        grant_dm = dm_pend & ~grant_if;
        if (grant_if | grant_dm) begin
          state_d = ACCESS;
          lat_d   = LW'(MEM_LATENCY - 1);
        end
        if (grant_if) begin
          starve_d = '0;
        end else if (grant_dm) begin
          if (!bus.if_req_i)
            starve_d = '0;
          else if (!starved)
            starve_d = starve_q + 1'b1;
        end
      end
      ACCESS: begin
        last = (lat_q == '0);
        if (last)
          state_d = RESP;
        else
          lat_d = lat_q - 1'b1;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      starve_q    <= '0;
      own_dm_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_data_q   <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      mem_en_q <= 1'b0;
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;

      if (grant_if | grant_dm) begin
        own_dm_q    <= grant_dm;
        mem_en_q    <= 1'b1;
        mem_we_q    <= grant_dm & (bus.dm_row_i == 2'b10);
        mem_addr_q  <= grant_dm ? bus.dm_addr_i : bus.if_addr_i;
        mem_wdata_q <= grant_dm ? bus.dm_wdata_i : '0;
      end

      // Read data lands on the final ACCESS edge, ack follows in RESP
      if (last) begin
        if (own_dm_q) begin
          dm_ack_q <= 1'b1;
          if (!mem_we_q)
            dm_rdata_q <= bus.mem_rdata_i;
        end else begin
          if_ack_q  <= 1'b1;
          if_data_q <= bus.mem_rdata_i;
        end
      end
    end
  end

  assign bus.mem_en_o    = mem_en_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_ack_o    = if_ack_q;
  assign bus.dm_ack_o    = dm_ack_q;
  assign bus.if_data_o   = if_data_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.stall_if_o  = bus.if_req_i & ~if_ack_q;
  assign bus.stall_mem_o = dm_pend & ~dm_ack_q;

endmodule
